// File: rtl/alu_seq_chunked.sv
// alu_seq_chunked: a WIDTH-bit ALU that works through the operands CHUNK bits
// per cycle, LSB chunk first, using one CHUNK-wide slice. The carry between
// chunks is kept in a flop. Operands come in and results go out on
// valid/ready handshakes. The zero and signed-overflow flags are produced
// from the last chunk.

// One CHUNK-wide slice. The operand b arrives already inverted for SUB, so
// ADD and SUB share the same adder. AND/OR never produce a carry.
module alu_seq_chunked_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  input  logic         arith,
  input  logic         orop,
  output logic [W-1:0] r,
  output logic         co
);

  logic [W:0] sum;

  // Adder and logic ops, selected by the latched operation class
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r   = a & b;
    co  = 1'b0;
    if (arith) begin
      r  = sum[W-1:0];
      co = sum[W];
    end else if (orop) begin
      r  = a | b;
    end
  end

endmodule

module alu_seq_chunked #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  // An uneven split would leave a partial chunk that the slice cannot cover.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("alu_seq_chunked: WIDTH must be a positive multiple of CHUNK");
  end

  // The latched operation. b is stored as the effective operand (~b for SUB),
  // so the slice and the overflow rule both see the same b'.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             arith;
    logic             orop;
  } req_t;

  logic [1:0]       state;
  req_t             req_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             nz;     // some chunk already processed was non-zero
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             zero_q;
  logic             ovf_q;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_r;
  logic             sl_co;
  logic             last;

  assign in_ready  = (state == S_IDLE) & rst_n;
  assign out_valid = (state == S_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign last      = (idx == LAST);

  // Pick the current chunk of both latched operands for the slice
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        sl_a = req_q.a[k*CHUNK +: CHUNK];
        sl_b = req_q.b[k*CHUNK +: CHUNK];
      end
    end
  end

  alu_seq_chunked_slice #(.W(CHUNK)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .ci    (carry),
    .arith (req_q.arith),
    .orop  (req_q.orop),
    .r     (sl_r),
    .co    (sl_co)
  );

  // Control: accept in IDLE, step through chunks in BUSY, hold in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      nz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            req_q.a     <= a;
            req_q.b     <= (op == OP_SUB) ? ~b : b;
            req_q.arith <= op[1];
            req_q.orop  <= (op == OP_OR);
            carry       <= cin;
            idx         <= '0;
            nz          <= 1'b0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          carry <= sl_co;
          nz    <= nz | (|sl_r);
          idx   <= idx + 1'b1;
          if (last) begin
            idx   <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result: each slice output lands in its own bit range; flags on the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == S_BUSY) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (idx == IW'(k)) s_q[k*CHUNK +: CHUNK] <= sl_r;
      end
      if (last) begin
        cout_q <= sl_co;
        zero_q <= ~nz & ~(|sl_r);
        ovf_q  <= req_q.arith
                & (req_q.a[WIDTH-1] == req_q.b[WIDTH-1])
                & (sl_r[CHUNK-1] != req_q.a[WIDTH-1]);
      end
    end
  end

endmodule
